// File: rtl/cfg_pkg.sv
// rtl/cfg_pkg.sv - shared types for the fabric configuration loader and readback blocks
// Purpose: loader state encoding and the bits_left counter width helper.
// Ports: none (package).
package cfg_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        SHIFT = 3'd2,
        SET   = 3'd3,
        DONE  = 3'd4
    } cfg_state_e;

    localparam int DEF_CHAIN_LEN = 1024;

    // Width of a counter that must hold every value 0..len inclusive.
    function automatic int cnt_w(input int len);
        return $clog2(len + 1);
    endfunction

    localparam int CNT_W = cnt_w(DEF_CHAIN_LEN);

endpackage

// File: rtl/cfg_serializer.sv
// rtl/cfg_serializer.sv - parallel-in serial-out word buffer feeding the configuration chain
// Purpose: holds one host word and presents its bits LSB first.
// Ports:
//   clk, rst     clock, asynchronous active-low reset
//   load         capture load_data / load_nbits this cycle
//   shift        advance to the next bit of the held word
//   load_data    host word; bit 0 is presented first
//   load_nbits   number of bits of load_data that belong to the chain (>=1)
//   bit_out      bit to launch this cycle (load_data[0] while loading)
//   empty        no bits of the current word remain after the one on the chain
module cfg_serializer
    import cfg_pkg::*;
#(
    parameter int WORD_W = 32,
    parameter int NB_W   = $clog2(WORD_W + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              shift,
    input  logic [WORD_W-1:0] load_data,
    input  logic [NB_W-1:0]   load_nbits,
    output logic              bit_out,
    output logic              empty
);

    logic [WORD_W-1:0] sreg_q, sreg_d;
    // Bits still to be launched after the one currently on the chain.
    logic [NB_W-1:0]   cnt_q, cnt_d;

    always_comb begin
        sreg_d = sreg_q;
        cnt_d  = cnt_q;
        if (load) begin
            // Bit 0 is launched in the same cycle as the capture.
            sreg_d = load_data >> 1;
            cnt_d  = load_nbits - NB_W'(1);
        end else if (shift && (cnt_q != '0)) begin
            sreg_d = sreg_q >> 1;
            cnt_d  = cnt_q - NB_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sreg_q <= '0;
            cnt_q  <= '0;
        end else begin
            sreg_q <= sreg_d;
            cnt_q  <= cnt_d;
        end
    end

    assign bit_out = load ? load_data[0] : sreg_q[0];
    assign empty   = (cnt_q == '0);

endmodule

// File: rtl/fabric_config_loader.sv
// rtl/fabric_config_loader.sv - host-to-CLB-chain configuration loader
// Purpose: accepts host words over valid/ready, shifts CHAIN_LEN bits into the
//   tile chain one per cycle, then pulses set for SET_CYCLES and reports done.
// Ports:
//   clk, rst     clock, asynchronous active-low reset
//   cfg_start    one-cycle request for a full chain load (IDLE/DONE only)
//   cfg_valid    host word valid
//   cfg_ready    loader accepts a word this cycle
//   cfg_data     host word, bit 0 shifted first
//   shift_hard   serial bit to chain head
//   set_hard     latch pulse to the chain
//   chain_cen    chain shift enable, high on bit-advance cycles only
//   busy         load in progress
//   done         load complete, held until the next start
//   bits_left    chain bits not yet shifted
module fabric_config_loader
    import cfg_pkg::*;
#(
    parameter int WORD_W     = 32,
    parameter int CHAIN_LEN  = 1024,
    parameter int SET_CYCLES = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         cfg_start,
    input  logic                         cfg_valid,
    output logic                         cfg_ready,
    input  logic [WORD_W-1:0]            cfg_data,
    output logic                         shift_hard,
    output logic                         set_hard,
    output logic                         chain_cen,
    output logic                         busy,
    output logic                         done,
    output logic [cnt_w(CHAIN_LEN)-1:0]  bits_left
);

    localparam int BL_W = cnt_w(CHAIN_LEN);
    localparam int NB_W = $clog2(WORD_W + 1);
    localparam int SC_W = $clog2(SET_CYCLES + 1);

    cfg_state_e        state_q, state_d;
    logic              cfg_ready_q, cfg_ready_d;
    logic              shift_hard_q, shift_hard_d;
    logic              set_hard_q, set_hard_d;
    logic              chain_cen_q, chain_cen_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [BL_W-1:0]   bits_left_q, bits_left_d;
    logic [SC_W-1:0]   set_cnt_q, set_cnt_d;

    logic              ser_load, ser_shift, ser_bit, ser_empty;
    logic [NB_W-1:0]   nbits;

    // The last word only carries the bits the chain still needs.
    always_comb begin
        if (32'(bits_left_q) >= WORD_W) begin
            nbits = NB_W'(WORD_W);
        end else begin
            nbits = NB_W'(bits_left_q);
        end
    end

    cfg_serializer #(
        .WORD_W (WORD_W),
        .NB_W   (NB_W)
    ) u_ser (
        .clk        (clk),
        .rst        (rst),
        .load       (ser_load),
        .shift      (ser_shift),
        .load_data  (cfg_data),
        .load_nbits (nbits),
        .bit_out    (ser_bit),
        .empty      (ser_empty)
    );

    always_comb begin
        state_d      = state_q;
        cfg_ready_d  = 1'b0;
        shift_hard_d = 1'b0;
        set_hard_d   = 1'b0;
        chain_cen_d  = 1'b0;
        busy_d       = busy_q;
        done_d       = done_q;
        bits_left_d  = bits_left_q;
        set_cnt_d    = set_cnt_q;
        ser_load     = 1'b0;
        ser_shift    = 1'b0;

        unique case (state_q)
            IDLE, DONE: begin
                if (cfg_start) begin
                    state_d     = LOAD;
                    cfg_ready_d = 1'b1;
                    busy_d      = 1'b1;
                    done_d      = 1'b0;
                    bits_left_d = BL_W'(CHAIN_LEN);
                end
            end
            LOAD: begin
                cfg_ready_d = 1'b1;
                if (cfg_valid && cfg_ready_q) begin
                    // Outputs are registered, so the first bit is launched at the handshake edge.
                    ser_load     = 1'b1;
                    cfg_ready_d  = 1'b0;
                    chain_cen_d  = 1'b1;
                    shift_hard_d = ser_bit;
                    bits_left_d  = bits_left_q - BL_W'(1);
                    state_d      = SHIFT;
                end
            end
            SHIFT: begin
                if (!ser_empty) begin
                    ser_shift    = 1'b1;
                    chain_cen_d  = 1'b1;
                    shift_hard_d = ser_bit;
                    bits_left_d  = bits_left_q - BL_W'(1);
                end else if (bits_left_q == '0) begin
                    state_d    = SET;
                    set_hard_d = 1'b1;
                    set_cnt_d  = SC_W'(1);
                end else begin
                    // This cycle is the single inter-word gap; ready rises in it.
                    state_d     = LOAD;
                    cfg_ready_d = 1'b1;
                end
            end
            SET: begin
                if (set_cnt_q == SC_W'(SET_CYCLES)) begin
                    state_d = DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end else begin
                    set_hard_d = 1'b1;
                    set_cnt_d  = set_cnt_q + SC_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            cfg_ready_q  <= 1'b0;
            shift_hard_q <= 1'b0;
            set_hard_q   <= 1'b0;
            chain_cen_q  <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            bits_left_q  <= BL_W'(CHAIN_LEN);
            set_cnt_q    <= '0;
        end else begin
            state_q      <= state_d;
            cfg_ready_q  <= cfg_ready_d;
            shift_hard_q <= shift_hard_d;
            set_hard_q   <= set_hard_d;
            chain_cen_q  <= chain_cen_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            bits_left_q  <= bits_left_d;
            set_cnt_q    <= set_cnt_d;
        end
    end

    assign cfg_ready  = cfg_ready_q;
    assign shift_hard = shift_hard_q;
    assign set_hard   = set_hard_q;
    assign chain_cen  = chain_cen_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign bits_left  = bits_left_q;

endmodule
